// File: rtl/keypad_time_entry_pkg.sv
// clock_pkg: shared types and limits for the digital clock keypad entry path.
// Contents: entry FSM state enum, BCD digit type, digit-position constants,
// validity limit constants and the pure digit_ok() validity function.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } entry_state_t;

  typedef logic [3:0] bcd_t;

  // Digit positions, left to right as displayed (HH:MM:SS).
  localparam logic [2:0] HOUR_T = 3'd0;
  localparam logic [2:0] HOUR_U = 3'd1;
  localparam logic [2:0] MIN_T  = 3'd2;
  localparam logic [2:0] MIN_U  = 3'd3;
  localparam logic [2:0] SEC_T  = 3'd4;
  localparam logic [2:0] SEC_U  = 3'd5;

  localparam bcd_t HOUR_T_MAX_24 = 4'd2;
  localparam bcd_t HOUR_T_MAX_12 = 4'd1;
  localparam bcd_t HOUR_U_MAX_20 = 4'd3;  // 24h: 20..23
  localparam bcd_t HOUR_U_MAX_10 = 4'd2;  // 12h: 10..12
  localparam bcd_t TENS_MAX      = 4'd5;
  localparam bcd_t UNITS_MAX     = 4'd9;

  localparam int NUM_LINES = 11;  // ten digit keys plus backspace
  localparam int BACK_LINE = 10;

  // Is digit d acceptable at position pos, given the staged hour tens?
  function automatic logic digit_ok(input logic [2:0] pos, input bcd_t d,
                                    input bcd_t hour_t, input logic mode24);
    logic ok;
    ok = 1'b0;
    case (pos)
      HOUR_T: ok = mode24 ? (d <= HOUR_T_MAX_24) : (d <= HOUR_T_MAX_12);
      HOUR_U: begin
        if (mode24) begin
          ok = (hour_t == 4'd2) ? (d <= HOUR_U_MAX_20) : (d <= UNITS_MAX);
        end else if (hour_t == 4'd1) begin
          ok = (d <= HOUR_U_MAX_10);
        end else if (hour_t == 4'd0) begin
          ok = (d >= 4'd1) && (d <= UNITS_MAX);  // hour 00 does not exist
        end else begin
          ok = (d <= UNITS_MAX);
        end
      end
      MIN_T, SEC_T: ok = (d <= TENS_MAX);
      MIN_U, SEC_U: ok = (d <= UNITS_MAX);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Register-side bus of the keypad entry block.
// Controller (master) drives start_time/start_alarm/cancel/load_value; the
// entry block (slave) returns the staged digits, cursor, status and strobes.
//
// Signalling contract: start_time, start_alarm and cancel are single-cycle
// synchronous requests sampled on the rising clock edge with no back-pressure;
// commit_time/commit_alarm/reject/timeout are single-cycle strobes, and
// digits is guaranteed valid in the cycle a commit strobe is high.
interface keypad_time_entry_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    start_time;
  logic                    start_alarm;
  logic                    cancel;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [2:0]              cursor;
  logic                    editing;
  logic                    target;
  logic                    commit_time;
  logic                    commit_alarm;
  logic                    reject;
  logic                    timeout;

  modport master (
    output start_time, start_alarm, cancel, load_value,
    input  digits, cursor, editing, target, commit_time, commit_alarm,
           reject, timeout
  );

  modport slave (
    input  start_time, start_alarm, cancel, load_value,
    output digits, cursor, editing, target, commit_time, commit_alarm,
           reject, timeout
  );
endinterface

// File: rtl/keypad_time_entry_debounce.sv
// key_debounce: 2-FF synchroniser plus stable-sample counter for one raw line.
// Ports: clk, rst_n (async active-low), raw (asynchronous input),
// level (debounced level, changes only after DEBOUNCE_CYCLES equal samples).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] stableCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      level     <= 1'b0;
      stableCnt <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the count.
      if (sync == level) begin
        stableCnt <= '0;
      end else if (stableCnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level     <= sync;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/keypad_time_entry.sv
// keypad_time_entry: keypad front end producing a validated HH:MM[:SS] entry
// for the time or alarm register.
// Ports: clk, rst_n (async active-low); key[9:0] and key_back raw keypad
// lines; bus (slave modport) carrying start/cancel/load requests and the
// digits/cursor/editing/target/commit/reject/timeout results; dbgState
// exposes the entry FSM state.
module keypad_time_entry
  import clock_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int MODE_24H        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           key,
  input  logic                 key_back,
  keypad_time_entry_if.slave   bus,
  output entry_state_t         dbgState
);
  localparam int         DW       = 4 * NUM_DIGITS;
  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);
  localparam logic       IS_24H   = (MODE_24H != 0);

  logic [NUM_LINES-1:0] rawLines;
  logic [NUM_LINES-1:0] lineLevel;
  logic                 anyPrevQ;
  logic                 pressEdge;
  logic                 singleLine;
  bcd_t                 keyDigit;

  entry_state_t stateQ, stateNext;
  logic [DW-1:0] digitsQ, digitsNext;
  logic [2:0]    cursorQ, cursorNext;
  logic          targetQ, targetNext;
  logic [TW-1:0] idleCntQ, idleCntNext;
  logic          rejectQ, rejectNext;
  logic          timeoutQ, timeoutNext;
  logic [4:0]    wrLsb;

  assign rawLines = {key_back, key};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (rawLines[i]),
      .level (lineLevel[i])
    );
  end

  // A press is the rising edge of "any line down"; holding or adding keys
  // while something is already down never produces another event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) anyPrevQ <= 1'b0;
    else        anyPrevQ <= |lineLevel;
  end

  assign pressEdge  = (|lineLevel) && !anyPrevQ;
  assign singleLine = $onehot(lineLevel);

  always_comb begin
    keyDigit = '0;
    for (int k = 0; k < 10; k++) begin
      if (lineLevel[k]) keyDigit = bcd_t'(k);
    end
  end

  // Digit 0 sits in the most significant nibble.
  assign wrLsb = 5'(4 * (NUM_DIGITS - 1 - int'(cursorQ)));

  always_comb begin
    stateNext   = stateQ;
    digitsNext  = digitsQ;
    cursorNext  = cursorQ;
    targetNext  = targetQ;
    idleCntNext = idleCntQ;
    rejectNext  = 1'b0;
    timeoutNext = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.start_time || bus.start_alarm) begin
          stateNext   = ENTRY;
          digitsNext  = bus.load_value;
          cursorNext  = '0;
          targetNext  = !bus.start_time;  // time wins when both are raised
          idleCntNext = '0;
        end
      end
      ENTRY: begin
        idleCntNext = idleCntQ + 1'b1;
        if (bus.cancel) begin
          stateNext  = IDLE;
          cursorNext = '0;
        end else if (pressEdge) begin
          idleCntNext = '0;
          if (!singleLine) begin
            rejectNext = 1'b1;
          end else if (lineLevel[BACK_LINE]) begin
            if (cursorQ != 3'd0) cursorNext = cursorQ - 3'd1;
          end else if (digit_ok(cursorQ, keyDigit, digitsQ[DW-1 -: 4], IS_24H)) begin
            digitsNext[wrLsb +: 4] = keyDigit;
            // A new hour tens invalidates whatever hour units was staged.
            if (cursorQ == 3'd0) digitsNext[4*(NUM_DIGITS-2) +: 4] = '0;
            if (cursorQ == LAST_POS) begin
              stateNext  = COMMIT;
              cursorNext = '0;
            end else begin
              cursorNext = cursorQ + 3'd1;
            end
          end else begin
            rejectNext = 1'b1;
          end
        end else if (idleCntQ == TW'(TIMEOUT_CYCLES - 1)) begin
          stateNext   = IDLE;
          cursorNext  = '0;
          timeoutNext = 1'b1;
          idleCntNext = '0;
        end
      end
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      digitsQ  <= '0;
      cursorQ  <= '0;
      targetQ  <= 1'b0;
      idleCntQ <= '0;
      rejectQ  <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      digitsQ  <= digitsNext;
      cursorQ  <= cursorNext;
      targetQ  <= targetNext;
      idleCntQ <= idleCntNext;
      rejectQ  <= rejectNext;
      timeoutQ <= timeoutNext;
    end
  end

  assign bus.digits       = digitsQ;
  assign bus.cursor       = cursorQ;
  assign bus.editing      = (stateQ == ENTRY);
  assign bus.target       = targetQ;
  assign bus.commit_time  = (stateQ == COMMIT) && !targetQ;
  assign bus.commit_alarm = (stateQ == COMMIT) && targetQ;
  assign bus.reject       = rejectQ;
  assign bus.timeout      = timeoutQ;
  assign dbgState         = stateQ;
endmodule

// File: tb/tb_keypad_time_entry.sv
// Testbench for keypad_time_entry: two instances share the keypad pins and
// control pulses -- one 24h / HH:MM, one 12h / HH:MM:SS. A behavioural model
// predicts strobe events into per-instance queues; a negedge monitor pops and
// compares them whenever a strobe appears.
module tb_keypad_time_entry;
  import clock_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 50;
  localparam int W   = 27;  // {kind[2:0], digits[23:0]}
  localparam int K_REJ = 1, K_CT = 2, K_CA = 3, K_TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  key = '0;
  logic        key_back = 1'b0;
  logic        start_time = 1'b0, start_alarm = 1'b0, cancel = 1'b0;
  logic [15:0] load24 = '0;
  logic [23:0] load12 = '0;
  entry_state_t dbg24, dbg12;

  keypad_time_entry_if #(.NUM_DIGITS(4)) bus24 ();
  keypad_time_entry_if #(.NUM_DIGITS(6)) bus12 ();

  assign bus24.start_time  = start_time;
  assign bus24.start_alarm = start_alarm;
  assign bus24.cancel      = cancel;
  assign bus24.load_value  = load24;
  assign bus12.start_time  = start_time;
  assign bus12.start_alarm = start_alarm;
  assign bus12.cancel      = cancel;
  assign bus12.load_value  = load12;

  keypad_time_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .MODE_24H(1))
    dut24 (.clk(clk), .rst_n(rst_n), .key(key), .key_back(key_back), .bus(bus24.slave), .dbgState(dbg24));
  keypad_time_entry #(.NUM_DIGITS(6), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .MODE_24H(0))
    dut12 (.clk(clk), .rst_n(rst_n), .key(key), .key_back(key_back), .bus(bus12.slave), .dbgState(dbg12));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // ---------------- reference model ----------------
  int m_nd[2]  = '{4, 6};
  bit m_24[2]  = '{1'b1, 1'b0};
  bit m_edit[2];
  bit m_tgt[2];
  int m_cur[2];
  int m_dig[2][6];

  function automatic logic [23:0] model_digits(input int u);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < m_nd[u]; i++) v = {v[19:0], 4'(m_dig[u][i])};
    return v;
  endfunction

  function automatic void push_exp(input int u, input int kind);
    logic [W-1:0] e;
    e = {3'(kind), model_digits(u)};
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  // Acceptability judged on the resulting clock value rather than per-digit tables.
  function automatic bit model_ok(input int u, input int pos, input int d);
    int tens, hour;
    tens = m_dig[u][0];
    hour = tens * 10 + d;
    case (pos)
      0: return m_24[u] ? (d * 10 <= 23) : (d * 10 <= 12);
      1: begin
        if (m_24[u]) return (tens <= 2) ? (hour <= 23) : 1'b1;
        else         return (tens <= 1) ? (hour >= 1 && hour <= 12) : 1'b1;
      end
      2, 4: return d * 10 <= 59;
      default: return d <= 9;
    endcase
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_edit[u] = 0; m_tgt[u] = 0; m_cur[u] = 0;
      for (int i = 0; i < 6; i++) m_dig[u][i] = 0;
    end
  endfunction

  function automatic void model_start(input bit t, input bit a);
    if (!(t || a)) return;
    for (int u = 0; u < 2; u++) begin
      if (m_edit[u]) continue;
      m_edit[u] = 1; m_tgt[u] = !t; m_cur[u] = 0;
      for (int i = 0; i < m_nd[u]; i++)
        m_dig[u][i] = (u == 0) ? int'(load24[4*(3-i) +: 4]) : int'(load12[4*(5-i) +: 4]);
    end
  endfunction

  function automatic void model_cancel();
    for (int u = 0; u < 2; u++) begin
      m_edit[u] = 0; m_cur[u] = 0;
    end
  endfunction

  function automatic void model_timeout();
    for (int u = 0; u < 2; u++) begin
      if (!m_edit[u]) continue;
      push_exp(u, K_TMO);
      m_edit[u] = 0; m_cur[u] = 0;
    end
  endfunction

  function automatic void model_press(input logic [10:0] lines);
    int d;
    for (int u = 0; u < 2; u++) begin
      if (!m_edit[u]) continue;
      if ($countones(lines) > 1) begin
        push_exp(u, K_REJ);
      end else if (lines[10]) begin
        if (m_cur[u] > 0) m_cur[u]--;
      end else begin
        d = 0;
        for (int k = 0; k < 10; k++) if (lines[k]) d = k;
        if (model_ok(u, m_cur[u], d)) begin
          m_dig[u][m_cur[u]] = d;
          if (m_cur[u] == 0) m_dig[u][1] = 0;
          if (m_cur[u] == m_nd[u] - 1) begin
            push_exp(u, m_tgt[u] ? K_CA : K_CT);
            m_edit[u] = 0; m_cur[u] = 0;
          end else begin
            m_cur[u]++;
          end
        end else begin
          push_exp(u, K_REJ);
        end
      end
    end
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cur24"}, 32'(bus24.cursor), 32'(m_cur[0]));
    check({tag, "_dig24"}, 32'(bus24.digits), 32'(model_digits(0)));
    check({tag, "_ed24"},  32'(bus24.editing), 32'(m_edit[0]));
    check({tag, "_cur12"}, 32'(bus12.cursor), 32'(m_cur[1]));
    check({tag, "_dig12"}, 32'(bus12.digits), 32'(model_digits(1)));
    check({tag, "_ed12"},  32'(bus12.editing), 32'(m_edit[1]));
    if (m_edit[0]) check({tag, "_tgt24"}, 32'(bus24.target), 32'(m_tgt[0]));
  endtask

  // ---------------- monitor ----------------
  task automatic mon_unit(input int u, input logic rej, input logic ct, input logic ca,
                          input logic tmo, input logic ed, input logic [23:0] dg);
    int nhi, kind;
    logic [W-1:0] obs, e;
    string tag;
    tag = (u == 0) ? "u24" : "u12";
    nhi = int'(rej) + int'(ct) + int'(ca) + int'(tmo);
    if (nhi == 0) return;
    check({tag, "_one_strobe"}, 32'(nhi), 32'd1);
    kind = ct ? K_CT : ca ? K_CA : tmo ? K_TMO : K_REJ;
    obs = {3'(kind), dg};
    if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      $display("FAIL %s_event actual=%0h required=none", tag, obs);
    end else begin
      e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check({tag, "_event"}, 32'(obs), 32'(e));
    end
    if (ct || ca) check({tag, "_edit_at_commit"}, 32'(ed), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_unit(0, bus24.reject, bus24.commit_time, bus24.commit_alarm, bus24.timeout,
               bus24.editing, {8'h00, bus24.digits});
      mon_unit(1, bus12.reject, bus12.commit_time, bus12.commit_alarm, bus12.timeout,
               bus12.editing, bus12.digits);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_entry(input bit t, input bit a, input logic [15:0] l24, input logic [23:0] l12);
    load24 = l24; load12 = l12;
    start_time = t; start_alarm = a;
    model_start(t, a);
    tick(1);
    start_time = 1'b0; start_alarm = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    model_cancel();
    tick(1);
    cancel = 1'b0;
  endtask

  function automatic logic [10:0] line_of(input int d);
    logic [10:0] one;
    one = 11'd1;
    return one << d;
  endfunction

  // Press and release a set of lines; optional bounce before settling, or a
  // cancel pulse landing in exactly the cycle the press is recognised.
  task automatic press(input logic [10:0] lines, input bit bounce, input bit collide);
    if (!collide) model_press(lines);
    if (bounce) begin
      for (int i = 0; i < 5; i++) begin
        {key_back, key} = (i % 2 == 0) ? lines : 11'd0;
        tick(2);
      end
    end
    {key_back, key} = lines;
    if (collide) begin
      tick(2 + DEB);
      pulse_cancel();
      tick(3);
    end else begin
      tick(2 + DEB + 4);
    end
    {key_back, key} = 11'd0;
    tick(DEB + 6);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dig24"}, 32'(bus24.digits), 32'd0);
    check({tag, "_cur24"}, 32'(bus24.cursor), 32'd0);
    check({tag, "_ed24"},  32'(bus24.editing), 32'd0);
    check({tag, "_tgt24"}, 32'(bus24.target), 32'd0);
    check({tag, "_strb24"}, 32'({bus24.commit_time, bus24.commit_alarm, bus24.reject, bus24.timeout}), 32'd0);
    check({tag, "_dig12"}, 32'(bus12.digits), 32'd0);
    check({tag, "_ed12"},  32'(bus12.editing), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen_early;
    logic [10:0] lines;
    int sel, d1, d2;
    logic [15:0] r24;
    logic [23:0] r12;

    model_reset();
    tick(2);
    check_all_zero("rst");
    rst_n = 1'b1;
    tick(2);
    check_all_zero("post_rst");

    // Clean entry 23:59 with exact press-to-write latency on the first digit.
    start_entry(1'b1, 1'b0, 16'h0000, 24'h000000);
    lines = line_of(2);
    model_press(lines);
    {key_back, key} = lines;
    tick(2 + DEB);
    check("lat_before", 32'(bus24.cursor), 32'd0);
    tick(1);
    check("lat_after", 32'(bus24.cursor), 32'd1);
    tick(3);
    {key_back, key} = 11'd0;
    tick(DEB + 6);
    press(line_of(3), 1'b0, 1'b0);
    press(line_of(5), 1'b0, 1'b0);
    press(line_of(9), 1'b0, 1'b0);
    check_state("t2359");
    pulse_cancel();

    // Bounce, hour-units limits, multi-key, backspace saturation.
    start_entry(1'b1, 1'b0, 16'h0000, 24'h000000);
    press(line_of(1), 1'b1, 1'b0);
    check_state("bounce");
    press(line_of(10), 1'b0, 1'b0);
    press(line_of(2), 1'b0, 1'b0);
    press(line_of(4), 1'b0, 1'b0);
    check_state("h24_rej");
    press(line_of(3), 1'b0, 1'b0);
    check_state("h24_ok");
    press(line_of(1) | line_of(2), 1'b0, 1'b0);
    check_state("multi");
    press(line_of(10), 1'b0, 1'b0);
    check_state("bs_c2");
    press(line_of(10), 1'b0, 1'b0);
    press(line_of(10), 1'b0, 1'b0);
    check_state("bs_sat");
    pulse_cancel();

    // Hour 00 rejected only by the 12h instance.
    start_entry(1'b1, 1'b0, 16'h0000, 24'h000000);
    press(line_of(0), 1'b0, 1'b0);
    press(line_of(0), 1'b0, 1'b0);
    check_state("h12_zero");
    pulse_cancel();

    // Alarm edit with preload, then cancel colliding with a key event.
    start_entry(1'b0, 1'b1, 16'h0730, 24'h073000);
    check_state("preload");
    press(line_of(1), 1'b0, 1'b0);
    check_state("clr_units");
    press(line_of(5), 1'b0, 1'b1);
    check_state("cancel_hit");

    // Inactivity timeout lands exactly TMO cycles after entry.
    start_entry(1'b1, 1'b0, 16'h1111, 24'h111111);
    model_timeout();
    seen_early = 0;
    for (int i = 1; i < TMO; i++) begin
      tick(1);
      if (bus24.timeout || !bus24.editing) seen_early++;
    end
    check("tmo_early", 32'(seen_early), 32'd0);
    tick(1);
    check("tmo_pulse", 32'(bus24.timeout), 32'd1);
    check("tmo_edit", 32'(bus24.editing), 32'd0);
    tick(2);

    // Asynchronous reset in the middle of an alarm entry.
    start_entry(1'b0, 1'b1, 16'h0000, 24'h000000);
    press(line_of(1), 1'b0, 1'b0);
    press(line_of(2), 1'b0, 1'b0);
    check_state("pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("mid_rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    start_entry(1'b1, 1'b1, 16'h0000, 24'h000000);
    press(line_of(1), 1'b0, 1'b0);
    press(line_of(2), 1'b0, 1'b0);
    press(line_of(3), 1'b0, 1'b0);
    press(line_of(4), 1'b0, 1'b0);
    check_state("after_rst");
    pulse_cancel();

    // Randomised entries.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) r24[4*i +: 4] = 4'($urandom_range(0, 9));
      for (int i = 0; i < 6; i++) r12[4*i +: 4] = 4'($urandom_range(0, 9));
      sel = $urandom_range(0, 2);
      start_entry(sel != 1, sel != 0, r24, r12);
      for (int k = $urandom_range(3, 8); k > 0; k--) begin
        sel = $urandom_range(0, 19);
        if (sel < 14) begin
          lines = line_of($urandom_range(0, 9));
        end else if (sel < 18) begin
          lines = line_of(10);
        end else begin
          d1 = $urandom_range(0, 9);
          d2 = (d1 + $urandom_range(1, 9)) % 10;
          lines = line_of(d1) | line_of(d2);
        end
        press(lines, 1'b0, 1'b0);
      end
      check_state($sformatf("rnd%0d", r));
      pulse_cancel();
    end

    tick(20);
    check("q24_left", 32'(exp_q0.size()), 32'd0);
    check("q12_left", 32'(exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
